code_lock_param: RTL and testbench

//  Parametrised successor of the single-code lock FSM. Takes a serial code entry as
//  one/zero button strobes, gated by a press latch released with unlatch.

---
 rtl/code_lock_param.sv | 162 ++++++++++++++++
 tb/tb_code_lock_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : code_lock_param                                                 |
// | Brief    : Parametrised serial code lock with press latch, relock and      |
// |            timed lockout after repeated wrong attempts.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module code_lock_param #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             one,
  input  logic                             zero,
  input  logic                             unlatch,
  input  logic                             relock,
  output logic                             unlock,
  output logic                             locked_out,
  output logic [$clog2(CODE_LEN+1)-1:0]    bit_count,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int BW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  // Only the most recent CODE_LEN-1 bits ever need to be remembered.
  localparam int SW = (CODE_LEN > 1) ? CODE_LEN - 1 : 1;

  localparam logic [BW-1:0] c_last_idx  = BW'(CODE_LEN - 1);
  localparam logic [FW-1:0] c_max_fails = FW'(MAX_FAILS);
  localparam logic [TW-1:0] c_lock_init = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t          r_state,      w_state_n;
  logic            r_latched,    w_latched_n;
  logic [SW-1:0]   r_shift,      w_shift_n;
  logic [BW-1:0]   r_bit_count,  w_bit_count_n;
  logic [FW-1:0]   r_fail_count, w_fail_count_n;
  logic [TW-1:0]   r_timer,      w_timer_n;
  logic            r_unlock,     w_unlock_n;
  logic            r_locked_out, w_locked_out_n;

  logic                w_accept;
  logic                w_bit;
  logic                w_last;
  logic                w_match;
  logic [FW-1:0]       w_fail_inc;
  logic [CODE_LEN-1:0] w_attempt;

  assign w_bit      = one;
  assign w_accept   = (r_state == ST_ENTRY) && !r_latched && (one || zero);
  assign w_last     = (r_bit_count == c_last_idx);
  assign w_fail_inc = r_fail_count + 1'b1;

  // Attempt as it would look once the current bit is shifted in.
  if (CODE_LEN == 1) begin : g_single
    logic w_unused_shift;
    assign w_attempt      = w_bit;
    assign w_unused_shift = ^r_shift;
  end else begin : g_multi
    assign w_attempt = {r_shift, w_bit};
  end

  assign w_match = (w_attempt == CODE);

  always_comb begin
    w_state_n      = r_state;
    w_shift_n      = r_shift;
    w_bit_count_n  = r_bit_count;
    w_fail_count_n = r_fail_count;
    w_timer_n      = r_timer;
    w_unlock_n     = r_unlock;
    w_locked_out_n = r_locked_out;
    w_latched_n    = unlatch ? 1'b0 : (w_accept ? 1'b1 : r_latched);

    case (r_state)
      ST_ENTRY: begin
        if (w_accept) begin
          w_shift_n = w_attempt[SW-1:0];
          if (w_last) begin
            w_bit_count_n = '0;
            if (w_match) begin
              w_state_n      = ST_OPEN;
              w_unlock_n     = 1'b1;
              w_fail_count_n = '0;
            end else if (w_fail_inc == c_max_fails) begin
              w_state_n      = ST_LOCKOUT;
              w_locked_out_n = 1'b1;
              w_timer_n      = c_lock_init;
              w_fail_count_n = c_max_fails;
            end else begin
              w_fail_count_n = w_fail_inc;
            end
          end else begin
            w_bit_count_n = r_bit_count + 1'b1;
          end
        end
      end

      ST_OPEN: begin
        if (relock) begin
          w_state_n  = ST_ENTRY;
          w_unlock_n = 1'b0;
          w_shift_n  = '0;
        end
      end

      ST_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_n      = ST_ENTRY;
          w_locked_out_n = 1'b0;
          w_fail_count_n = '0;
        end else begin
          w_timer_n = r_timer - 1'b1;
        end
      end

      default: begin
        w_state_n      = ST_ENTRY;
        w_unlock_n     = 1'b0;
        w_locked_out_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ENTRY;
      r_latched    <= 1'b0;
      r_shift      <= '0;
      r_bit_count  <= '0;
      r_fail_count <= '0;
      r_timer      <= '0;
      r_unlock     <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_latched    <= w_latched_n;
      r_shift      <= w_shift_n;
      r_bit_count  <= w_bit_count_n;
      r_fail_count <= w_fail_count_n;
      r_timer      <= w_timer_n;
      r_unlock     <= w_unlock_n;
      r_locked_out <= w_locked_out_n;
    end
  end

  assign unlock     = r_unlock;
  assign locked_out = r_locked_out;
  assign bit_count  = r_bit_count;
  assign fail_count = r_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_code_lock_param                                              |
// | Brief    : Directed and randomized bench for code_lock_param against a     |
// |            queue-based reference model.                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_code_lock_param;

  localparam int            CL = 4;
  localparam logic [CL-1:0] CD = 4'b1011;
  localparam int            MF = 3;
  localparam int            LC = 16;

  logic clk = 1'b0;
  logic reset, one, zero, unlatch, relock;
  logic unlock, locked_out;
  logic [$clog2(CL+1)-1:0] bit_count;
  logic [$clog2(MF+1)-1:0] fail_count;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: attempt bits kept as a queue, lockout as a remaining-cycle count.
  int m_bits[$];
  bit m_latched;
  bit m_open;
  int m_fails;
  int m_lock_left;

  code_lock_param #(
    .CODE_LEN(CL), .CODE(CD), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .reset(reset), .one(one), .zero(zero), .unlatch(unlatch),
    .relock(relock), .unlock(unlock), .locked_out(locked_out),
    .bit_count(bit_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_latched   = 1'b0;
    m_open      = 1'b0;
    m_fails     = 0;
    m_lock_left = 0;
  endtask

  task automatic model_step(input bit o, input bit z, input bit u, input bit r);
    bit acc;
    int val;
    acc = !m_open && (m_lock_left == 0) && !m_latched && (o || z);
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_open) begin
      if (r) m_open = 1'b0;
    end else if (acc) begin
      m_bits.push_back(o ? 1 : 0);
      if (m_bits.size() == CL) begin
        val = 0;
        foreach (m_bits[i]) val = val * 2 + m_bits[i];
        m_bits.delete();
        if (val == int'(CD)) begin
          m_open  = 1'b1;
          m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails == MF) m_lock_left = LC;
        end
      end
    end
    m_latched = u ? 1'b0 : (acc ? 1'b1 : m_latched);
  endtask

  task automatic check_outputs();
    check("unlock",     int'(unlock),     int'(m_open));
    check("locked_out", int'(locked_out), (m_lock_left > 0) ? 1 : 0);
    check("bit_count",  int'(bit_count),  m_bits.size());
    check("fail_count", int'(fail_count), m_fails);
  endtask

  // One clock cycle: drive, advance the model, then compare after the edge.
  task automatic cyc(input bit o, input bit z, input bit u, input bit r);
    one = o; zero = z; unlatch = u; relock = r;
    model_step(o, z, u, r);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    one = 0; zero = 0; unlatch = 0; relock = 0;
    reset = 1'b0;
    #2;
    check("rst_unlock",     int'(unlock),     0);
    check("rst_locked_out", int'(locked_out), 0);
    check("rst_bit_count",  int'(bit_count),  0);
    check("rst_fail_count", int'(fail_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic press(input bit b);
    cyc(b, !b, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic enter_code(input logic [CL-1:0] v);
    logic [CL-1:0] tmp;
    tmp = v;
    for (int i = CL - 1; i >= 0; i--) press(tmp[i]);
  endtask

  initial begin
    int cnt;
    int r;
    reset = 1'b1; one = 0; zero = 0; unlatch = 0; relock = 0;
    model_reset();
    #1;
    do_reset();

    // Correct code opens at the final accept edge.
    enter_code(CD);
    check("t1_unlock", int'(unlock), 1);
    check("t1_fails", int'(fail_count), 0);

    // Held button counts once until released.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    check("t2_held", int'(bit_count), 1);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    check("t2_second", int'(bit_count), 2);

    // Three wrong attempts trigger a lockout of exactly LC cycles.
    do_reset();
    enter_code('0);
    check("t3_fail1", int'(fail_count), 1);
    enter_code('0);
    check("t3_fail2", int'(fail_count), 2);
    for (int i = 0; i < CL - 1; i++) press(1'b0);
    cyc(0, 1, 0, 0);
    check("t3_lock_on", int'(locked_out), 1);
    cnt = 1;
    for (int i = 0; i < 4 * LC; i++) begin
      cyc(i[0], !i[0], i[1], i[2]);
      if (locked_out) cnt++;
      else break;
    end
    check("t3_lock_len", cnt, LC);
    check("t3_fails_clr", int'(fail_count), 0);

    // Wrong then right; presses while open are ignored; relock closes.
    do_reset();
    enter_code('0);
    check("t4_fail", int'(fail_count), 1);
    enter_code(CD);
    check("t4_unlock", int'(unlock), 1);
    check("t4_fails0", int'(fail_count), 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("t4_open_bc", int'(bit_count), 0);
    cyc(0, 0, 0, 1);
    check("t4_relock", int'(unlock), 0);

    // one&zero enters '1'; a press with unlatch leaves the latch open.
    do_reset();
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    check("t5_unlock", int'(unlock), 1);

    // Reset mid-attempt and mid-lockout, then a correct code still opens.
    do_reset();
    press(1'b1);
    press(1'b0);
    do_reset();
    for (int k = 0; k < MF; k++) enter_code('0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    check("t6_locked", int'(locked_out), 1);
    do_reset();
    enter_code(CD);
    check("t6_unlock", int'(unlock), 1);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) do_reset();
      else cyc(($urandom % 3) == 0, ($urandom % 3) == 0,
               ($urandom % 2) == 0, ($urandom % 6) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
